// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared definitions for the CPU I/O bridge.
//   - byte addresses of every mapped register
//   - register index within a timer block, CTRL bit positions, MODE encodings
//   - timer FSM state enum
//   - apply_be(): byte-enable merge used by every writable register
package io_bridge_pkg;

  localparam logic [31:0] ADDR_T0_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] ADDR_T0_PRESET = 32'h0000_7F04;
  localparam logic [31:0] ADDR_T0_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] ADDR_T1_CTRL   = 32'h0000_7F10;
  localparam logic [31:0] ADDR_T1_PRESET = 32'h0000_7F14;
  localparam logic [31:0] ADDR_T1_COUNT  = 32'h0000_7F18;
  localparam logic [31:0] ADDR_GPIO_OUT  = 32'h0000_7F20;
  localparam logic [31:0] ADDR_GPIO_IN   = 32'h0000_7F24;

  // Word index of a register inside a 16-byte timer block
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_t;

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/io_bridge_timer.sv
// io_timer: one programmable down-counter with CTRL/PRESET/COUNT registers.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   wr_en        CPU write strobe already qualified by block decode
//   reg_idx      word index in block (0 CTRL, 1 PRESET, 2 COUNT, 3 unmapped)
//   wd, be       write data and byte enables
//   rd           combinational read data for reg_idx
//   irq          irq_flag & IM
//
// state   | meaning
// IDLE    | stopped, waits for EN
// LOAD    | copy PRESET into COUNT
// CNT     | decrement COUNT once per cycle
// INT     | terminal count reached; one-shot stops, auto-reload restarts
module io_timer
  import io_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  reg_idx,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic [31:0] rd,
  output logic        irq
);

  timer_state_t state;
  logic         en;
  logic [1:0]   mode;
  logic         im;
  logic [31:0]  preset;
  logic [31:0]  count;
  logic         irq_flag;

  logic        wr_ctrl;
  logic        wr_preset;
  logic [3:0]  ctrl_cur;
  logic [3:0]  ctrl_new;

  assign wr_ctrl   = wr_en && (reg_idx == REG_CTRL);
  assign wr_preset = wr_en && (reg_idx == REG_PRESET);

  always_comb begin
    ctrl_cur                          = '0;
    ctrl_cur[CTRL_EN_BIT]             = en;
    ctrl_cur[CTRL_MODE_LSB +: 2]      = mode;
    ctrl_cur[CTRL_IM_BIT]             = im;
  end

  // Only byte 0 of CTRL holds storage; upper bits read as zero
  assign ctrl_new = be[0] ? wd[3:0] : ctrl_cur;

  always_comb begin
    case (reg_idx)
      REG_CTRL:   rd = {28'b0, ctrl_cur};
      REG_PRESET: rd = preset;
      REG_COUNT:  rd = count;
      default:    rd = '0;
    endcase
  end

  assign irq = irq_flag & im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      en       <= 1'b0;
      mode     <= MODE_ONESHOT;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_preset) preset <= apply_be(preset, wd, be);

      case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (preset == '0) begin
            // Zero preset fires immediately instead of wrapping
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end else begin
            count <= preset;
            state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count == 32'd1) begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end else begin
            count <= count - 32'd1;
          end
        end
        ST_INT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (mode == MODE_RELOAD) begin
            // Reload is folded into this cycle so the irq period is PRESET+1
            irq_flag <= 1'b0;
            if (preset == '0) begin
              state <= ST_LOAD;
            end else begin
              count <= preset;
              state <= ST_CNT;
            end
          end else begin
            en    <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A CPU CTRL write overrides any same-cycle hardware EN clear / irq set
      if (wr_ctrl) begin
        en       <= ctrl_new[CTRL_EN_BIT];
        mode     <= ctrl_new[CTRL_MODE_LSB +: 2];
        im       <= ctrl_new[CTRL_IM_BIT];
        irq_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: CPU-side I/O block with timers, GPIO and interrupt collection.
// Build option: define IO_BRIDGE_TIMER1_EN to include timer 1; otherwise its
// addresses read 0, ignore writes and HWInt[3] is tied low.
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   PrAddr[31:2]       CPU word address
//   PrWD, PrBE         write data and byte enables
//   IOWrite            write strobe
//   PrRD               combinational read data
//   HWInt[7:2]         {ext_int synchronised, T1 irq, T0 irq}
//   ext_int            asynchronous external interrupt sources
//   gpio_out, gpio_in  general-purpose output register / input pins
module io_bridge
  import io_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] PrAddr,
  input  logic [31:0] PrWD,
  input  logic [3:0]  PrBE,
  input  logic        IOWrite,
  output logic [31:0] PrRD,
  output logic [7:2]  HWInt,
  input  logic [3:0]  ext_int,
  output logic [31:0] gpio_out,
  input  logic [31:0] gpio_in
);

  logic [31:0] byte_addr;
  logic        t0_blk;
  logic [31:0] t0_rd;
  logic        t0_irq;
  logic        t1_irq;
  logic        gpio_out_hit;
  logic        gpio_in_hit;
  logic [3:0]  ext_sync1;
  logic [3:0]  ext_sync2;

  assign byte_addr    = {PrAddr, 2'b00};
  assign t0_blk       = (byte_addr[31:4] == ADDR_T0_CTRL[31:4]);
  assign gpio_out_hit = (byte_addr == ADDR_GPIO_OUT);
  assign gpio_in_hit  = (byte_addr == ADDR_GPIO_IN);

  io_timer u_t0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (IOWrite && t0_blk),
    .reg_idx (PrAddr[3:2]),
    .wd      (PrWD),
    .be      (PrBE),
    .rd      (t0_rd),
    .irq     (t0_irq)
  );

`ifdef IO_BRIDGE_TIMER1_EN
  logic        t1_blk;
  logic [31:0] t1_rd;

  assign t1_blk = (byte_addr[31:4] == ADDR_T1_CTRL[31:4]);

  io_timer u_t1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (IOWrite && t1_blk),
    .reg_idx (PrAddr[3:2]),
    .wd      (PrWD),
    .be      (PrBE),
    .rd      (t1_rd),
    .irq     (t1_irq)
  );
`else
  assign t1_irq = 1'b0;
`endif

  always_comb begin
    PrRD = '0;
    if (t0_blk) begin
      PrRD = t0_rd;
    end
`ifdef IO_BRIDGE_TIMER1_EN
    else if (t1_blk) begin
      PrRD = t1_rd;
    end
`endif
    else if (gpio_out_hit) begin
      PrRD = gpio_out;
    end else if (gpio_in_hit) begin
      PrRD = gpio_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out  <= '0;
      ext_sync1 <= '0;
      ext_sync2 <= '0;
    end else begin
      if (IOWrite && gpio_out_hit) gpio_out <= apply_be(gpio_out, PrWD, PrBE);
      ext_sync1 <= ext_int;
      ext_sync2 <= ext_sync1;
    end
  end

  assign HWInt = {ext_sync2, t1_irq, t0_irq};

endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:2] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrBE;
  logic        IOWrite;
  logic [31:0] PrRD;
  logic [7:2]  HWInt;
  logic [3:0]  ext_int;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  io_bridge dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .PrBE     (PrBE),
    .IOWrite  (IOWrite),
    .PrRD     (PrRD),
    .HWInt    (HWInt),
    .ext_int  (ext_int),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_empty: got %h expected none", got);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, got, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    PrAddr  = addr[31:2];
    PrWD    = data;
    PrBE    = be;
    IOWrite = 1'b1;
    @(posedge clk);
    #1;
    IOWrite = 1'b0;
    PrBE    = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    sb_push(tag, exp);
    PrAddr  = addr[31:2];
    IOWrite = 1'b0;
    #1;
    sb_pop(PrRD);
  endtask

  task automatic irq0_cycles(input string tag, input int n, input int period, input int first);
    for (int k = 1; k <= n; k++) begin
      sb_push(tag, (k >= first && ((k - first) % period) == 0) ? 32'd1 : 32'd0);
      cyc();
      sb_pop({31'b0, HWInt[2]});
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    PrAddr  = '0;
    PrWD    = '0;
    PrBE    = '0;
    IOWrite = 1'b0;
    ext_int = '0;
    gpio_in = 32'hCAFE_0123;
    #12;
    check("rst_hwint", {26'b0, HWInt}, 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
    rd_chk("rst_t0_ctrl", 32'h7F00, 32'h0);
    rd_chk("rst_t0_preset", 32'h7F04, 32'h0);
    rd_chk("rst_t0_count", 32'h7F08, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot, PRESET=5: irq at 7th cycle after CTRL write
    wr(32'h7F04, 32'd5, 4'hF);
    wr(32'h7F00, 32'h9, 4'hF);
    irq0_cycles("oneshot_irq", 7, 100, 7);
    rd_chk("oneshot_count", 32'h7F08, 32'h0);
    cyc();
    check("oneshot_hold", {31'b0, HWInt[2]}, 32'h1);
    rd_chk("oneshot_ctrl_en_clr", 32'h7F00, 32'h8);
    wr(32'h7F00, 32'h8, 4'hF);
    check("oneshot_ack", {31'b0, HWInt[2]}, 32'h0);

    // PRESET=0 fires right after LOAD
    wr(32'h7F04, 32'd0, 4'hF);
    wr(32'h7F00, 32'h9, 4'hF);
    irq0_cycles("preset0_irq", 2, 100, 2);
    rd_chk("preset0_count", 32'h7F08, 32'h0);
    wr(32'h7F00, 32'h0, 4'hF);

    // Auto-reload PRESET=3: pulses at 5,9,13,17
    wr(32'h7F04, 32'd3, 4'hF);
    wr(32'h7F00, 32'hB, 4'hF);
    irq0_cycles("reload_irq", 17, 4, 5);
    wr(32'h7F00, 32'h0, 4'hF);
    cyc();
    check("reload_stop", {31'b0, HWInt[2]}, 32'h0);
    rd_chk("reload_count_frozen", 32'h7F08, 32'd3);
    wr(32'h7F08, 32'hFFFF_FFFF, 4'hF);
    rd_chk("count_ro", 32'h7F08, 32'd3);
    wr(32'h7F04, 32'h1234_5678, 4'b0011);
    rd_chk("preset_be", 32'h7F04, 32'h0000_5678);

    // CTRL write on the same edge as the irq set: write wins
    wr(32'h7F04, 32'd2, 4'hF);
    wr(32'h7F00, 32'h9, 4'hF);
    cyc(); cyc(); cyc();
    wr(32'h7F00, 32'h9, 4'hF);
    check("collide_irq_e4", {31'b0, HWInt[2]}, 32'h0);
    cyc();
    check("collide_irq_e5", {31'b0, HWInt[2]}, 32'h0);
    rd_chk("collide_ctrl", 32'h7F00, 32'h8);
    wr(32'h7F00, 32'h0, 4'hF);

    // GPIO
    wr(32'h7F20, 32'hAABB_CCDD, 4'hF);
    wr(32'h7F20, 32'h1122_3344, 4'h5);
    check("gpio_out_port", gpio_out, 32'hAA22_CC44);
    rd_chk("gpio_out_rd", 32'h7F20, 32'hAA22_CC44);
    wr(32'h7F24, 32'h0, 4'hF);
    wr(32'h7F40, 32'h5555_5555, 4'hF);
    wr(32'h1000_7F20, 32'h0, 4'hF);
    check("gpio_out_kept", gpio_out, 32'hAA22_CC44);
    rd_chk("gpio_in_rd", 32'h7F24, 32'hCAFE_0123);
    gpio_in = 32'h0BAD_F00D;
    rd_chk("gpio_in_rd2", 32'h7F24, 32'h0BAD_F00D);
    rd_chk("unmapped_rd", 32'h7F40, 32'h0);
    rd_chk("upper_bits_rd", 32'h1000_7F20, 32'h0);

    // External interrupt synchroniser
    ext_int = 4'b0100;
    cyc();
    check("ext_e1", {26'b0, HWInt}, 32'h0);
    cyc();
    check("ext_e2", {26'b0, HWInt}, 32'h10);
    ext_int = 4'b0000;
    cyc(); cyc();
    check("ext_clr", {26'b0, HWInt}, 32'h0);

    // Timer 1 block
    wr(32'h7F10, 32'h9, 4'hF);
`ifdef IO_BRIDGE_TIMER1_EN
    rd_chk("t1_ctrl_rd", 32'h7F10, 32'h9);
`else
    rd_chk("t1_ctrl_rd", 32'h7F10, 32'h0);
`endif
    wr(32'h7F10, 32'h0, 4'hF);
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("t1_hwint3", {31'b0, HWInt[3]}, 32'h0);
    end

    // Reset in the middle of counting
    wr(32'h7F04, 32'd10, 4'hF);
    wr(32'h7F00, 32'h9, 4'hF);
    for (int k = 0; k < 9; k++) cyc();
    rd_chk("mid_count", 32'h7F08, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_hwint", {26'b0, HWInt}, 32'h0);
    check("arst_gpio_out", gpio_out, 32'h0);
    rd_chk("arst_count", 32'h7F08, 32'h0);
    rd_chk("arst_ctrl", 32'h7F00, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    irq0_cycles("post_rst_irq", 20, 100, 1000);
    rd_chk("post_rst_count", 32'h7F08, 32'h0);

    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_leftover: got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
